// File: rtl/word_demux.sv
// word_demux: buffered 1-to-2 word distributor.
//   One WIDTH-bit word per cycle enters on a valid/ready input and is steered
//   by in_sel into channel A (sel=1) or channel B (sel=0). Each channel owns a
//   DEPTH-entry FIFO with its own valid/ready output, so a stalled consumer on
//   one channel never blocks the other.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   in_valid/in_ready/in_sel/in_data   input handshake and routing select
//   a_valid/a_ready/a_data/a_level     channel A head and occupancy
//   b_valid/b_ready/b_data/b_level     channel B head and occupancy

// Per-channel FIFO lane.
module word_demux_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int LW    = $clog2(DEPTH+1),
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic [LW-1:0]    level,
  output logic             full
);
  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [PW-1:0]               wr_ptr, rd_ptr;
  logic                        pop;

  assign valid = (level != '0);
  assign full  = (level == LW'(DEPTH));
  // Empty-gating keeps the head at zero after reset without clearing memory.
  assign data  = valid ? mem[rd_ptr] : '0;
  assign pop   = valid & ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;  // DEPTH is a power of two: wraps naturally
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage needs no reset: nothing is visible until level says so.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end
endmodule

module word_demux #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_sel,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       a_valid,
  input  logic                       a_ready,
  output logic [WIDTH-1:0]           a_data,
  output logic [$clog2(DEPTH+1)-1:0] a_level,
  output logic                       b_valid,
  input  logic                       b_ready,
  output logic [WIDTH-1:0]           b_data,
  output logic [$clog2(DEPTH+1)-1:0] b_level
);
  localparam int NUM_LANES = 2;   // lane 1 = A, lane 0 = B, matching in_sel
  localparam int LW        = $clog2(DEPTH+1);

  logic [NUM_LANES-1:0]            push, rdy, vld, full;
  logic [NUM_LANES-1:0][WIDTH-1:0] dat;
  logic [NUM_LANES-1:0][LW-1:0]    lvl;

  // Full blocks the input even if a pop frees a slot this cycle: in_ready
  // depends only on registered level and in_sel.
  assign in_ready = ~full[in_sel];
  assign rdy      = {a_ready, b_ready};

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    assign push[l] = in_valid & ~full[l] & (in_sel == l[0]);
    word_demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push[l]),
      .wdata (in_data),
      .ready (rdy[l]),
      .valid (vld[l]),
      .data  (dat[l]),
      .level (lvl[l]),
      .full  (full[l])
    );
  end

  assign a_valid = vld[1];
  assign a_data  = dat[1];
  assign a_level = lvl[1];
  assign b_valid = vld[0];
  assign b_data  = dat[0];
  assign b_level = lvl[0];
endmodule

// File: tb/tb_word_demux.sv
// tb_word_demux: directed self-checking bench for word_demux (WIDTH=32, DEPTH=2).
module tb_word_demux;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_sel;
  logic [31:0] in_data;
  logic        a_valid, a_ready, b_valid, b_ready;
  logic [31:0] a_data, b_data;
  logic [1:0]  a_level, b_level;

  int nerr = 0;
  int nchk = 0;

  word_demux #(.WIDTH(32), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .a_level(a_level),
    .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data), .b_level(b_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Streams n words base..base+n-1 to B, checking order at every pop.
  task automatic stream_b(input int n, input int base, input bit toggle);
    int  sent = 0;
    int  rcv  = 0;
    int  cyc  = 0;
    bit  pu;
    while (rcv < n && cyc < 200) begin
      in_sel   = 1'b0;
      in_valid = (sent < n);
      in_data  = 32'(base + sent);
      b_ready  = toggle ? (cyc % 2 == 0) : 1'b1;
      #1;
      pu = in_valid && in_ready;
      if (b_valid && b_ready) begin
        chk("b_order", b_data, 32'(base + rcv));
        rcv++;
      end
      tick();
      if (pu) sent++;
      cyc++;
    end
    in_valid = 1'b0;
    chk("b_count", 32'(rcv), 32'(n));
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_sel = 1'b0; in_data = '0;
    a_ready = 1'b0; b_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    #1;
    chk("rst_a_valid", 32'(a_valid), 32'd0);
    chk("rst_b_valid", 32'(b_valid), 32'd0);
    chk("rst_a_level", 32'(a_level), 32'd0);
    chk("rst_b_level", 32'(b_level), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    tick();

    // Route
    a_ready = 1'b1; b_ready = 1'b1;
    in_valid = 1'b1; in_sel = 1'b1; in_data = 32'hDEADBEEF;
    #1 chk("route_a_not_early", 32'(a_valid), 32'd0);
    tick();
    in_sel = 1'b0; in_data = 32'h12345678;
    #1;
    chk("route_a_valid", 32'(a_valid), 32'd1);
    chk("route_a_data", a_data, 32'hDEADBEEF);
    chk("route_b_not_early", 32'(b_valid), 32'd0);
    tick();
    in_valid = 1'b0;
    #1;
    chk("route_a_drained", 32'(a_valid), 32'd0);
    chk("route_b_valid", 32'(b_valid), 32'd1);
    chk("route_b_data", b_data, 32'h12345678);
    tick();
    chk("route_b_drained", 32'(b_valid), 32'd0);

    // Fill A with 3 words, hold the third
    a_ready = 1'b0;
    in_valid = 1'b1; in_sel = 1'b1; in_data = 32'hA1;
    tick();
    in_data = 32'hA2;
    tick();
    in_valid = 1'b0; in_sel = 1'b0;
    #1;
    chk("fill_a_level", 32'(a_level), 32'd2);
    chk("fill_ready_sel0", 32'(in_ready), 32'd1);
    in_sel = 1'b1;
    #1 chk("fill_ready_sel1", 32'(in_ready), 32'd0);
    in_valid = 1'b1; in_data = 32'hA3;
    tick();
    chk("fill_hold_level", 32'(a_level), 32'd2);
    chk("fill_hold_head", a_data, 32'hA1);
    // Full: pop at this edge must not let A3 in at the same edge.
    a_ready = 1'b1;
    #1 chk("no_full_bypass", 32'(in_ready), 32'd0);
    tick();
    chk("drain1_head", a_data, 32'hA2);
    chk("drain1_level", 32'(a_level), 32'd1);
    tick();   // pop A2, push A3
    in_valid = 1'b0;
    #1;
    chk("drain2_head", a_data, 32'hA3);
    chk("drain2_level", 32'(a_level), 32'd1);
    tick();
    chk("drain3_empty", 32'(a_valid), 32'd0);

    // Simultaneous push/pop at level 1
    a_ready = 1'b0; in_valid = 1'b1; in_sel = 1'b1; in_data = 32'h55;
    tick();
    a_ready = 1'b1; in_data = 32'h66;
    tick();
    in_valid = 1'b0; a_ready = 1'b0;
    #1;
    chk("simul_level", 32'(a_level), 32'd1);
    chk("simul_head", a_data, 32'h66);
    a_ready = 1'b1;
    tick();
    a_ready = 1'b0;
    #1 chk("simul_empty", 32'(a_valid), 32'd0);

    // in_valid=0 means no push
    in_valid = 1'b0; in_sel = 1'b1; in_data = 32'hBAD;
    tick();
    chk("novalid_level", 32'(a_level), 32'd0);

    // Wrap on B with toggling ready
    stream_b(10, 0, 1'b1);
    chk("wrap_b_empty", 32'(b_level), 32'd0);

    // Isolation: A full and stalled, B streams
    a_ready = 1'b0; in_valid = 1'b1; in_sel = 1'b1; in_data = 32'hC1;
    tick();
    in_data = 32'hC2;
    tick();
    in_valid = 1'b0;
    stream_b(4, 100, 1'b0);
    chk("iso_a_level", 32'(a_level), 32'd2);
    chk("iso_a_head", a_data, 32'hC1);

    // Asynchronous reset mid-cycle with a_level=2
    #1 rst_n = 1'b0;
    #1;
    chk("arst_a_valid", 32'(a_valid), 32'd0);
    chk("arst_a_level", 32'(a_level), 32'd0);
    chk("arst_a_data", a_data, 32'd0);
    chk("arst_b_valid", 32'(b_valid), 32'd0);
    tick();
    rst_n = 1'b1;
    a_ready = 1'b1;
    tick();
    chk("post_rst_no_replay", 32'(a_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
